// File: rtl/capture_ctrl.sv
// capture_ctrl -- sample-RAM capture sequencer for a logic-analyser style core.
// Fills a circular sample RAM with pre-trigger history, waits for a trigger,
// records trig_pos post-trigger samples, then holds DONE until the host acks.
// Optional feature macro: AUTO_TRIG_EN (forces a trigger after AUTO_TMO armed
// samples when no real trigger arrives).
//
// Handshake note: capture_start and clr_cap_done are single-cycle requests
// accepted only in IDLE and DONE respectively; smpl_en is a one-cycle strobe
// that, in PRETRIG/ARMED/POSTTRIG, is forwarded combinationally to we and
// advances waddr on the following edge.
module capture_ctrl #(
   parameter int          AW       = 9,
   parameter logic [15:0] AUTO_TMO = 16'd1024
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          capture_start,
   input  logic [AW-1:0] trig_pos,
   input  logic          smpl_en,
   input  logic          triggered,
   input  logic          clr_cap_done,
   output logic          armed,
   output logic          set_capture_done,
   output logic          capture_done,
   output logic          we,
   output logic [AW-1:0] waddr,
   output logic [AW-1:0] trig_addr,
   output logic          auto_trigd,
   output logic [2:0]    dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_PRETRIG  = 3'd1,
      S_ARMED    = 3'd2,
      S_POSTTRIG = 3'd3,
      S_DONE     = 3'd4
   } state_t;

   localparam logic [AW-1:0] ONE_AW  = AW'(1);
   localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
   localparam logic [AW:0]   DEPTH   = {1'b1, {AW{1'b0}}};

   state_t        state_q, state_d;
   logic [AW-1:0] waddr_q, waddr_d;
   logic [AW-1:0] trig_addr_q, trig_addr_d;
   logic [AW-1:0] trig_pos_q, trig_pos_d;
   logic [AW:0]   pre_cnt_q, pre_cnt_d;
   logic [AW:0]   post_cnt_q, post_cnt_d;
   logic          auto_q, auto_d;
   logic          set_cd_q, set_cd_d;
   logic          we_c;

   logic [AW-1:0] waddr_inc;
   logic [AW:0]   pre_inc;
   logic [AW:0]   post_inc;
   logic [AW:0]   pre_tgt;
   logic [AW:0]   post_tgt;

`ifdef AUTO_TRIG_EN
   logic [15:0] tmo_q, tmo_d;
   logic        tmo_hit;

   // Timeout fires on the armed sample that brings the count up to AUTO_TMO.
   always_comb begin
      tmo_hit = (tmo_q >= AUTO_TMO) ||
                (smpl_en && ((tmo_q + 16'd1) >= AUTO_TMO));
   end
`else
   logic tmo_hit;
   logic unused_tmo;
   assign tmo_hit    = 1'b0;
   assign unused_tmo = ^AUTO_TMO;
`endif

   assign waddr_inc = waddr_q + ONE_AW;
   assign pre_inc   = pre_cnt_q + CNT_ONE;
   assign post_inc  = post_cnt_q + CNT_ONE;
   // Pre-trigger depth is whatever the RAM holds beyond the post-trigger window.
   assign pre_tgt   = DEPTH - {1'b0, trig_pos_q};
   assign post_tgt  = {1'b0, trig_pos_q};

   // Next-state, counter and write-path logic.
   always_comb begin
      state_d     = state_q;
      waddr_d     = waddr_q;
      trig_addr_d = trig_addr_q;
      trig_pos_d  = trig_pos_q;
      pre_cnt_d   = pre_cnt_q;
      post_cnt_d  = post_cnt_q;
      auto_d      = auto_q;
      we_c        = 1'b0;
`ifdef AUTO_TRIG_EN
      tmo_d       = tmo_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (capture_start) begin
               state_d    = S_PRETRIG;
               trig_pos_d = trig_pos;
               pre_cnt_d  = '0;
               post_cnt_d = '0;
               auto_d     = 1'b0;
            end
         end

         S_PRETRIG: begin
            we_c = smpl_en;
            if (smpl_en) begin
               waddr_d   = waddr_inc;
               pre_cnt_d = pre_inc;
               if (pre_inc == pre_tgt) begin
                  state_d = S_ARMED;
`ifdef AUTO_TRIG_EN
                  tmo_d   = '0;
`endif
               end
            end
         end

         S_ARMED: begin
            we_c = smpl_en;
            if (smpl_en) begin
               // A write in the trigger cycle still belongs to the history.
               waddr_d   = waddr_inc;
               pre_cnt_d = pre_inc;
`ifdef AUTO_TRIG_EN
               if (tmo_q != 16'hFFFF) begin
                  tmo_d = tmo_q + 16'd1;
               end
`endif
            end
            if (triggered || tmo_hit) begin
               trig_addr_d = waddr_q;
               post_cnt_d  = '0;
               auto_d      = !triggered && tmo_hit;
               if (trig_pos_q == '0) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_POSTTRIG;
               end
            end
         end

         S_POSTTRIG: begin
            we_c = smpl_en;
            if (smpl_en) begin
               waddr_d    = waddr_inc;
               post_cnt_d = post_inc;
               if (post_inc == post_tgt) begin
                  state_d = S_DONE;
               end
            end
         end

         S_DONE: begin
            if (clr_cap_done) begin
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      set_cd_d = (state_d == S_DONE) && (state_q != S_DONE);
   end

   // State and datapath registers; reset dominates every other input.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         waddr_q     <= '0;
         trig_addr_q <= '0;
         trig_pos_q  <= '0;
         pre_cnt_q   <= '0;
         post_cnt_q  <= '0;
         auto_q      <= 1'b0;
         set_cd_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         waddr_q     <= waddr_d;
         trig_addr_q <= trig_addr_d;
         trig_pos_q  <= trig_pos_d;
         pre_cnt_q   <= pre_cnt_d;
         post_cnt_q  <= post_cnt_d;
         auto_q      <= auto_d;
         set_cd_q    <= set_cd_d;
      end
   end

`ifdef AUTO_TRIG_EN
   // Armed-sample timeout counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         tmo_q <= '0;
      end else begin
         tmo_q <= tmo_d;
      end
   end
`endif

   assign armed            = (state_q == S_ARMED);
   assign capture_done     = (state_q == S_DONE);
   assign set_capture_done = set_cd_q;
   assign we               = we_c;
   assign waddr            = waddr_q;
   assign trig_addr        = trig_addr_q;
`ifdef AUTO_TRIG_EN
   assign auto_trigd       = auto_q && ((state_q == S_POSTTRIG) || (state_q == S_DONE));
`else
   assign auto_trigd       = 1'b0;
`endif
   assign dbg_state        = state_q;

endmodule

// File: tb/tb_capture_ctrl.sv
// tb_capture_ctrl -- randomized and directed bench for capture_ctrl (AW=4,
// AUTO_TMO=8). Expected outputs come from a capture model that tracks write
// counts and trigger status rather than controller states.
module tb_capture_ctrl;

   localparam int AW    = 4;
   localparam int DEPTH = 16;
   localparam int TMO   = 8;
`ifdef AUTO_TRIG_EN
   localparam bit AUTO_ON = 1'b1;
`else
   localparam bit AUTO_ON = 1'b0;
`endif

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic          capture_start;
   logic [AW-1:0] trig_pos;
   logic          smpl_en;
   logic          triggered;
   logic          clr_cap_done;
   logic          armed;
   logic          set_capture_done;
   logic          capture_done;
   logic          we;
   logic [AW-1:0] waddr;
   logic [AW-1:0] trig_addr;
   logic          auto_trigd;
   logic [2:0]    dbg_state;

   capture_ctrl #(.AW(AW), .AUTO_TMO(16'd8)) dut (
      .clk              (clk),
      .rst              (rst),
      .capture_start    (capture_start),
      .trig_pos         (trig_pos),
      .smpl_en          (smpl_en),
      .triggered        (triggered),
      .clr_cap_done     (clr_cap_done),
      .armed            (armed),
      .set_capture_done (set_capture_done),
      .capture_done     (capture_done),
      .we               (we),
      .waddr            (waddr),
      .trig_addr        (trig_addr),
      .auto_trigd       (auto_trigd),
      .dbg_state        (dbg_state)
   );

   // ---------------- scoreboard counters ----------------
   int n_total = 0;
   int n_bad   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   bit m_active;   // a capture is in progress or awaiting ack
   int m_tp;       // latched post-trigger sample count
   int m_wr;       // history writes since capture_start
   bit m_trig;     // trigger accepted
   int m_post;     // writes after trigger
   bit m_done;
   bit m_first;    // first cycle of completion
   int m_waddr;
   int m_taddr;
   bit m_auto;
   int m_awr;      // writes made while waiting for a trigger

   function automatic void model_reset();
      m_active = 0; m_tp = 0; m_wr = 0; m_trig = 0; m_post = 0;
      m_done = 0; m_first = 0; m_waddr = 0; m_taddr = 0; m_auto = 0; m_awr = 0;
   endfunction

   task automatic compare();
      bit reached;
      reached = (m_wr >= DEPTH - m_tp);
      check("armed",  armed,            m_active && reached && !m_trig);
      check("done",   capture_done,     m_done);
      check("set_cd", set_capture_done, m_first);
      check("we",     we,               smpl_en && m_active && !m_done);
      check("waddr",  waddr,            m_waddr);
      check("taddr",  trig_addr,        m_taddr);
      check("auto",   auto_trigd,       AUTO_ON && m_auto && m_trig && m_active);
   endtask

   function automatic void model_step(bit r, bit cs, int tp, bit se, bit tr, bit clr);
      bit fire;
      int old_wa;
      if (r) begin
         model_reset();
         return;
      end
      m_first = 0;
      if (!m_active) begin
         if (cs) begin
            m_active = 1; m_tp = tp; m_wr = 0; m_trig = 0;
            m_post = 0; m_done = 0; m_auto = 0;
         end
      end else if (m_done) begin
         if (clr) begin
            m_active = 0;
            m_done   = 0;
         end
      end else if (m_wr < DEPTH - m_tp) begin
         if (se) begin
            m_wr++;
            m_waddr = (m_waddr + 1) % DEPTH;
            if (m_wr == DEPTH - m_tp) m_awr = 0;
         end
      end else if (!m_trig) begin
         fire   = tr || (AUTO_ON && (m_awr + int'(se) >= TMO));
         old_wa = m_waddr;
         if (se) begin
            m_wr++;
            m_awr++;
            m_waddr = (m_waddr + 1) % DEPTH;
         end
         if (fire) begin
            m_taddr = old_wa;
            m_trig  = 1;
            m_auto  = !tr;
            m_post  = 0;
            if (m_tp == 0) begin
               m_done  = 1;
               m_first = 1;
            end
         end
      end else begin
         if (se) begin
            m_post++;
            m_waddr = (m_waddr + 1) % DEPTH;
            if (m_post == m_tp) begin
               m_done  = 1;
               m_first = 1;
            end
         end
      end
   endfunction

   // ---------------- driver ----------------
   // Called at a falling edge: drive, compare settled outputs, advance model,
   // then step through the rising edge back to the next falling edge.
   task automatic cycle(input bit r, input bit cs, input int tp, input bit se,
                        input bit tr, input bit clr);
      rst           = r;
      capture_start = cs;
      trig_pos      = AW'(tp);
      smpl_en       = se;
      triggered     = tr;
      clr_cap_done  = clr;
      #2;
      compare();
      model_step(r, cs, tp, se, tr, clr);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) cycle(0, 0, 0, 1, 0, 0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst = 1'b1; capture_start = 0; trig_pos = '0; smpl_en = 0;
      triggered = 0; clr_cap_done = 0;
      model_reset();
      @(posedge clk);
      @(negedge clk);

      // Reset state.
      cycle(0, 0, 0, 0, 0, 0);
      check("rst_waddr", waddr, 0);

      // Basic capture, trig_pos=4, starting from waddr 0.
      cycle(0, 1, 4, 0, 0, 0);
      for (int i = 0; i < 12; i++) cycle(0, 0, 0, 1, 0, 0);
      check("armed_after_12", armed, 1);
      cycle(0, 1, 9, 1, 0, 0);            // capture_start while armed is ignored
      for (int i = 0; i < 2; i++) cycle(0, 0, 0, 1, 0, 0);
      cycle(0, 0, 0, 1, 1, 0);            // trigger on the 4th armed cycle
      check("trig_addr_15", trig_addr, 15);
      for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 1, 0);
      check("done_after_post", capture_done, 1);
      cycle(0, 1, 9, 1, 0, 0);            // capture_start in DONE is ignored
      idle_cycles(2);
      cycle(0, 0, 0, 1, 0, 1);
      check("idle_after_clr", capture_done, 0);

      // trig_pos=0: straight to DONE, no post writes; held until ack.
      cycle(0, 1, 0, 0, 0, 0);
      for (int i = 0; i < 16; i++) cycle(0, 0, 0, 1, 0, 0);
      cycle(0, 0, 0, 1, 1, 0);
      idle_cycles(5);
      check("tp0_done_held", capture_done, 1);
      cycle(0, 0, 0, 0, 0, 1);

      // Trigger during pre-trigger fill has no effect.
      cycle(0, 1, 4, 0, 0, 0);
      for (int i = 0; i < 11; i++) cycle(0, 0, 0, 1, 1, 0);
      check("no_early_arm", armed, 0);
      cycle(0, 0, 0, 1, 1, 0);
      cycle(0, 0, 0, 0, 1, 0);
      for (int i = 0; i < 6; i++) cycle(0, 0, 0, 1, 0, 0);
      cycle(0, 0, 0, 0, 0, 1);

      // Reset in the middle of the post-trigger phase.
      cycle(0, 1, 8, 0, 0, 0);
      for (int i = 0; i < 8; i++) cycle(0, 0, 0, 1, 0, 0);
      cycle(0, 0, 0, 1, 1, 0);
      for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 0, 0);
      cycle(1, 0, 0, 1, 0, 0);
      check("rst_mid_waddr", waddr, 0);
      for (int i = 0; i < 10; i++) cycle(0, 0, 0, 1, 0, 0);

      // Long wait while armed with no real trigger.
      cycle(0, 1, 8, 0, 0, 0);
      for (int i = 0; i < 8; i++) cycle(0, 0, 0, 1, 0, 0);
      for (int i = 0; i < 100; i++) cycle(0, 0, 0, 1, 0, 0);
      check("armed_wait", armed, !AUTO_ON);
      check("auto_flag", auto_trigd, AUTO_ON);
      cycle(0, 0, 0, 1, 1, 0);
      for (int i = 0; i < 8; i++) cycle(0, 0, 0, 1, 0, 0);
      cycle(0, 0, 0, 0, 0, 1);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         cycle($urandom_range(0, 299) == 0,
               $urandom_range(0, 5) == 0,
               int'($urandom_range(0, 15)),
               $urandom_range(0, 9) < 7,
               $urandom_range(0, 7) == 0,
               $urandom_range(0, 3) == 0);
      end

      cycle(1, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
